instr_decode: RTL and testbench

INSTR_DECODE -- requirements
Module: instr_decode

---
 rtl/instr_decode.sv | 163 ++++++++++++++++
 tb/tb_instr_decode.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode.sv
// Instruction decoder driving an 8-entry weight file and a multiply-accumulate step detector.
// Define STEP_SATURATE_EN to make step_count stop at 16'hFFFF; otherwise it wraps to zero.
module instr_decode (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instruction,
    output logic        instr_ready,
    output logic        busy,
    output logic [15:0] step_count,
    output logic        step_pulse,
    output logic        illegal_op,
    input  logic [2:0]  weight_rd_addr,
    output logic [7:0]  weight_rd_data
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR2  = 3'd1,
        MUL0 = 3'd2,
        MUL1 = 3'd3,
        CMP  = 3'd4
    } state_t;

    localparam logic [3:0] OP_CLEAR = 4'b0010;
    localparam logic [3:0] OP_UPD_A = 4'b0110;
    localparam logic [3:0] OP_UPD_B = 4'b1010;
    localparam logic [3:0] OP_COUNT = 4'b1100;

    state_t        state_reg;
    logic [2:0]    wr_addr_reg;
    logic [7:0]    wr_data_reg;
    logic [7:0]    a_reg;
    logic [7:0]    b_reg;
    logic [16:0]   acc_reg;
    logic [15:0]   step_count_reg;
    logic [15:0]   step_count_next;
    logic          step_pulse_reg;
    logic          illegal_op_reg;
    logic [7:0]    rd_data_reg;
    logic [7:0][7:0] w_val;

    logic [3:0]    opcode;
    logic          accept;
    logic          is_clear;
    logic          is_update;
    logic          is_count;
    logic          unused_instr_bits;

    assign opcode    = instruction[3:0];
    assign accept    = instr_valid && instr_ready;
    assign is_clear  = (opcode == OP_CLEAR);
    assign is_update = (opcode == OP_UPD_A) || (opcode == OP_UPD_B);
    assign is_count  = (opcode == OP_COUNT);

    assign unused_instr_bits = ^instruction[31:26];

    assign instr_ready    = (state_reg == IDLE) && !reset;
    assign busy           = (state_reg != IDLE) && !reset;
    assign step_count     = step_count_reg;
    assign step_pulse     = step_pulse_reg;
    assign illegal_op     = illegal_op_reg;
    assign weight_rd_data = rd_data_reg;

`ifdef STEP_SATURATE_EN
    assign step_count_next = (step_count_reg == 16'hFFFF) ? step_count_reg
                                                          : step_count_reg + 16'd1;
`else
    assign step_count_next = step_count_reg + 16'd1;
`endif

    // One register per weight; the WR2 write occurs a cycle after the first write,
    // so with equal addresses the second data naturally ends up in the register.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_weight
            logic [7:0] w_reg;
            logic       first_hit;
            logic       second_hit;

            assign first_hit  = accept && is_update && (instruction[6:4] == 3'(gi));
            assign second_hit = (state_reg == WR2) && (wr_addr_reg == 3'(gi));

            always_ff @(posedge clk) begin
                if (reset || (accept && is_clear)) begin
                    w_reg <= 8'd0;
                end else if (second_hit) begin
                    w_reg <= wr_data_reg;
                end else if (first_hit) begin
                    w_reg <= instruction[14:7];
                end
            end

            assign w_val[gi] = w_reg;
        end
    endgenerate

    // Debug read returns the pre-edge contents; no bypass from a concurrent write.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_reg <= 8'd0;
        end else begin
            rd_data_reg <= w_val[weight_rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            wr_addr_reg    <= 3'd0;
            wr_data_reg    <= 8'd0;
            a_reg          <= 8'd0;
            b_reg          <= 8'd0;
            acc_reg        <= 17'd0;
            step_count_reg <= 16'd0;
            step_pulse_reg <= 1'b0;
            illegal_op_reg <= 1'b0;
        end else begin
            step_pulse_reg <= 1'b0;
            illegal_op_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (is_update) begin
                            wr_addr_reg <= instruction[17:15];
                            wr_data_reg <= instruction[25:18];
                            state_reg   <= WR2;
                        end else if (is_count) begin
                            a_reg     <= instruction[11:4];
                            b_reg     <= instruction[19:12];
                            state_reg <= MUL0;
                        end else if (!is_clear) begin
                            illegal_op_reg <= 1'b1;
                        end
                    end
                end
                WR2: begin
                    state_reg <= IDLE;
                end
                MUL0: begin
                    acc_reg   <= 17'(a_reg) * 17'(w_val[0]);
                    state_reg <= MUL1;
                end
                MUL1: begin
                    // 255*255*2 fits in 17 bits, so the sum cannot overflow.
                    acc_reg   <= acc_reg + 17'(b_reg) * 17'(w_val[1]);
                    state_reg <= CMP;
                end
                CMP: begin
                    if (acc_reg >= {1'b0, w_val[2], w_val[3]}) begin
                        step_pulse_reg <= 1'b1;
                        step_count_reg <= step_count_next;
                    end
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_decode.sv
// Self-checking bench for instr_decode: directed scenarios plus random instructions
// checked against a weight-array/step-counter reference model.
module tb_instr_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instruction;
    logic        instr_ready;
    logic        busy;
    logic [15:0] step_count;
    logic        step_pulse;
    logic        illegal_op;
    logic [2:0]  weight_rd_addr;
    logic [7:0]  weight_rd_data;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mw [8];
    logic [15:0] msc;

    instr_decode dut (
        .clk            (clk),
        .reset          (reset),
        .instr_valid    (instr_valid),
        .instruction    (instruction),
        .instr_ready    (instr_ready),
        .busy           (busy),
        .step_count     (step_count),
        .step_pulse     (step_pulse),
        .illegal_op     (illegal_op),
        .weight_rd_addr (weight_rd_addr),
        .weight_rd_data (weight_rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_upd(input logic [3:0] op, input logic [2:0] a1,
                                           input logic [7:0] d1, input logic [2:0] a2,
                                           input logic [7:0] d2, input logic [5:0] hi);
        logic [31:0] v;
        v = {hi, d2, a2, d1, a1, op};
        return v;
    endfunction

    function automatic logic [31:0] mk_cnt(input logic [7:0] a, input logic [7:0] b,
                                           input logic [11:0] hi);
        logic [31:0] v;
        v = {hi, b, a, 4'b1100};
        return v;
    endfunction

    function automatic logic [15:0] bump(input logic [15:0] c);
`ifdef STEP_SATURATE_EN
        return (c == 16'hFFFF) ? c : c + 16'd1;
`else
        return c + 16'd1;
`endif
    endfunction

    // Called at a negedge; returns at the first negedge after the accept edge.
    task automatic issue(input logic [31:0] ins);
        instr_valid = 1'b1;
        instruction = ins;
        chk("ready_before_accept", instr_ready, 1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instruction = $urandom;
        @(negedge clk);
    endtask

    task automatic check_weights(input string tag);
        for (int i = 0; i < 8; i++) begin
            weight_rd_addr = 3'(i);
            @(negedge clk);
            chk($sformatf("%s_w%0d", tag, i), weight_rd_data, mw[i]);
        end
    endtask

    task automatic run_instr(input logic [31:0] ins, input bit sweep);
        logic [3:0]  op;
        int unsigned acc;
        int unsigned thr;
        bit          det;
        op = ins[3:0];
        if (op == 4'b0010) begin
            issue(ins);
            chk("clr_ready", instr_ready, 1);
            chk("clr_busy", busy, 0);
            chk("clr_illegal", illegal_op, 0);
            chk("clr_count", step_count, msc);
            for (int i = 0; i < 8; i++) mw[i] = 8'd0;
        end else if (op == 4'b0110 || op == 4'b1010) begin
            mw[ins[6:4]] = ins[14:7];
            issue(ins);
            chk("upd_ready_low", instr_ready, 0);
            chk("upd_busy", busy, 1);
            weight_rd_addr = ins[6:4];
            @(negedge clk);
            chk("upd_first_write", weight_rd_data, mw[ins[6:4]]);
            chk("upd_ready_back", instr_ready, 1);
            chk("upd_busy_done", busy, 0);
            mw[ins[17:15]] = ins[25:18];
        end else if (op == 4'b1100) begin
            acc = ins[11:4] * mw[0] + ins[19:12] * mw[1];
            thr = mw[2] * 256 + mw[3];
            det = (acc >= thr);
            issue(ins);
            for (int c = 0; c < 3; c++) begin
                chk($sformatf("cnt_busy_c%0d", c), busy, 1);
                chk($sformatf("cnt_ready_c%0d", c), instr_ready, 0);
                chk($sformatf("cnt_pulse_c%0d", c), step_pulse, 0);
                if (c < 2) @(negedge clk);
            end
            @(negedge clk);
            if (det) msc = bump(msc);
            chk("cnt_pulse_t3", step_pulse, 32'(det));
            chk("cnt_ready_t3", instr_ready, 1);
            chk("cnt_count", step_count, msc);
            $display("count A=%0d B=%0d acc=%0d thr=%0d det=%0d step_count=%0h",
                     ins[11:4], ins[19:12], acc, thr, det, step_count);
            if (sweep) begin
                @(negedge clk);
                chk("cnt_pulse_after", step_pulse, 0);
            end
        end else begin
            issue(ins);
            chk("ill_pulse", illegal_op, 1);
            chk("ill_ready", instr_ready, 1);
            chk("ill_busy", busy, 0);
            @(negedge clk);
            chk("ill_pulse_clear", illegal_op, 0);
        end
        if (op != 4'b1100) $display("instr 0x%08h op=%0h step_count=%0h", ins, op, step_count);
        if (sweep) check_weights($sformatf("op%0h", op));
    endtask

    initial begin
        logic [31:0] ins;
        logic [3:0]  op;
        int          sel;

        reset = 1'b1;
        instr_valid = 1'b0;
        instruction = 32'd0;
        weight_rd_addr = 3'd0;
        for (int i = 0; i < 8; i++) mw[i] = 8'd0;
        msc = 16'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready", instr_ready, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        #1;
        chk("rst_count", step_count, 0);
        chk("rst_pulse", step_pulse, 0);
        chk("rst_illegal", illegal_op, 0);
        chk("rst_rd_data", weight_rd_data, 0);
        chk("rst_ready_after", instr_ready, 1);
        @(negedge clk);
        check_weights("rst");

        // Directed scenarios
        run_instr(mk_upd(4'b0110, 3'd0, 8'h10, 3'd7, 8'h00, 6'h00), 1);
        run_instr(mk_upd(4'b0110, 3'd0, 8'd2, 3'd1, 8'd3, 6'h2A), 1);
        run_instr(mk_upd(4'b1010, 3'd2, 8'h00, 3'd3, 8'h40, 6'h15), 1);
        run_instr(mk_cnt(8'h10, 8'h10, 12'hABC), 1);
        run_instr(mk_cnt(8'h01, 8'h01, 12'h123), 1);
        chk("count_stays_1", step_count, 1);
        run_instr(mk_upd(4'b0110, 3'd3, 8'hAA, 3'd3, 8'h55, 6'h3F), 1);
        run_instr(32'hFFFF_FFFF, 1);

        // Back-to-back: update followed immediately by count and illegal
        run_instr(mk_upd(4'b1010, 3'd0, 8'hFF, 3'd1, 8'hFF, 6'h01), 0);
        run_instr(mk_cnt(8'hFF, 8'hFF, 12'h000), 0);
        run_instr(32'h0000_0001, 1);
        run_instr(32'h0000_0002, 1);

        // Random instructions
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 11);
            ins = $urandom;
            if (sel == 0) begin
                ins[3:0] = 4'b0010;
            end else if (sel <= 4) begin
                ins[3:0] = (sel[0]) ? 4'b0110 : 4'b1010;
            end else if (sel <= 9) begin
                ins[3:0] = 4'b1100;
            end else begin
                do op = 4'($urandom_range(0, 15));
                while (op == 4'b0010 || op == 4'b0110 || op == 4'b1010 || op == 4'b1100);
                ins[3:0] = op;
            end
            run_instr(ins, ($urandom_range(0, 2) != 0));
        end
        check_weights("rand_end");

        // Overflow of step_count
        run_instr(mk_upd(4'b0110, 3'd0, 8'd2, 3'd1, 8'd3, 6'h00), 1);
        run_instr(mk_upd(4'b0110, 3'd2, 8'h00, 3'd3, 8'h40, 6'h00), 1);
        force dut.step_count_reg = 16'hFFFF;
        @(negedge clk);
        release dut.step_count_reg;
        msc = 16'hFFFF;
        @(negedge clk);
        chk("preset_ffff", step_count, 16'hFFFF);
        run_instr(mk_cnt(8'h10, 8'h10, 12'h000), 1);
`ifdef STEP_SATURATE_EN
        chk("overflow_sat", step_count, 16'hFFFF);
`else
        chk("overflow_wrap", step_count, 16'h0000);
`endif

        // Reset while in MUL1
        run_instr(mk_upd(4'b0110, 3'd4, 8'h77, 3'd5, 8'h88, 6'h00), 1);
        issue(mk_cnt(8'hFF, 8'hFF, 12'h000));
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mrst_ready", instr_ready, 0);
        chk("mrst_busy", busy, 0);
        @(negedge clk);
        chk("mrst_pulse", step_pulse, 0);
        chk("mrst_count", step_count, 0);
        reset = 1'b0;
        #1;
        chk("mrst_idle", instr_ready, 1);
        for (int i = 0; i < 8; i++) mw[i] = 8'd0;
        msc = 16'd0;
        @(negedge clk);
        chk("mrst_pulse_later", step_pulse, 0);
        chk("mrst_count_later", step_count, 0);
        check_weights("mrst");
        $display("reset during MUL1 step_count=%0h", step_count);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
